// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and FSM state type.
package mdu_ctrl_pkg;

  localparam int MDOP_LEN      = 3;
  localparam int DEF_MULT_LAT  = 5;
  localparam int DEF_DIV_LAT   = 10;

  typedef enum logic [MDOP_LEN-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } mdop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic is_muldiv(mdop_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(mdop_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational product and quotient/remainder; HI/LO results for the latched op.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  mdop_e       op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, uq, ur;
  logic        div_zero;

  // Sign-extended operands give the signed product in the low 64 bits.
  assign prod_u   = {32'd0, a_i} * {32'd0, b_i};
  assign prod_s   = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign div_zero = (b_i == 32'd0);

  always_comb begin
    abs_a = a_i[31] ? (~a_i + 32'd1) : a_i;
    abs_b = b_i[31] ? (~b_i + 32'd1) : b_i;
    q_mag = div_zero ? 32'd0 : abs_a / abs_b;
    r_mag = div_zero ? 32'd0 : abs_a % abs_b;
    uq    = div_zero ? 32'd0 : a_i / b_i;
    ur    = div_zero ? 32'd0 : a_i % b_i;
    hi_o  = 32'd0;
    lo_o  = 32'd0;
    case (op_i)
      OP_MULT:  {hi_o, lo_o} = prod_s;
      OP_MULTU: {hi_o, lo_o} = prod_u;
      OP_DIV: begin
        if (div_zero) begin
          lo_o = 32'hFFFF_FFFF;
          hi_o = a_i;
        end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
          lo_o = 32'h8000_0000;
          hi_o = 32'd0;
        end else begin
          lo_o = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
          hi_o = a_i[31] ? (32'd0 - r_mag) : r_mag;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          lo_o = 32'hFFFF_FFFF;
          hi_o = a_i;
        end else begin
          lo_o = uq;
          hi_o = ur;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: IDLE/BUSY FSM, latency counter, HI/LO
// registers, pipeline stall generation and MFHI/MFLO read data.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [MDOP_LEN-1:0] op,
  input  logic [31:0]         rs,
  input  logic [31:0]         rt,
  input  logic                GeneralFlush,
  output logic                busy,
  output logic                stall,
  output logic [31:0]         HI,
  output logic [31:0]         LO,
  output logic [31:0]         MDUE
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  mdop_e            op_q;
  logic [31:0]      rs_q, rt_q, hi_q, lo_q;
  logic [31:0]      res_hi, res_lo;
  mdop_e            op_in;
  logic             accept;

  function automatic logic [CNT_W-1:0] lat_of(mdop_e o);
    return is_mul(o) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
  endfunction

  assign op_in  = mdop_e'(op);
  assign accept = start && !GeneralFlush && (state_q == ST_IDLE);

  mdu_arith u_arith (
    .op_i (op_q),
    .a_i  (rs_q),
    .b_i  (rt_q),
    .hi_o (res_hi),
    .lo_o (res_lo)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_muldiv(op_in)) begin
              op_q    <= op_in;
              rs_q    <= rs;
              rt_q    <= rt;
              cnt_q   <= lat_of(op_in);
              state_q <= ST_BUSY;
            end else if (op_in == OP_MTHI) begin
              hi_q <= rs;
            end else if (op_in == OP_MTLO) begin
              lo_q <= rs;
            end
          end
        end
        ST_BUSY: begin
          // A flush while cnt is still at its load value kills the op itself.
          if (GeneralFlush && (cnt_q == lat_of(op_q))) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q <= CNT_W'(1)) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign stall = start && busy;
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_comb begin
    MDUE = 32'd0;
    if (op_in == OP_MFHI)      MDUE = hi_q;
    else if (op_in == OP_MFLO) MDUE = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table, hand-written corner
// sequences and randomized ops against an arithmetic reference model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        GeneralFlush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy, stall;
  logic [31:0] HI, LO, MDUE;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .rs           (rs),
    .rt           (rt),
    .GeneralFlush (GeneralFlush),
    .busy         (busy),
    .stall        (stall),
    .HI           (HI),
    .LO           (LO),
    .MDUE         (MDUE)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_lat(logic [2:0] o);
    if (o <= 3'd1) return 5;
    if (o <= 3'd3) return 10;
    return 0;
  endfunction

  // Reference results from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_calc(logic [2:0] o, logic [31:0] a, logic [31:0] b,
                                           logic [31:0] hi, logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start = 1'b1;
    op = o;
    rs = a;
    rt = b;
    step();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
    end
    $display("[TB] op=%0d rs=%h rt=%h -> HI=%h LO=%h busy_cycles=%0d", o, a, b, HI, LO, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, n;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;

    vecs[0] = '{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[2] = '{3'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[4] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[5] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[6] = '{3'd3, 32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF};
    vecs[7] = '{3'd4, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[8] = '{3'd5, 32'h0000_0055, 32'd0,         32'h0000_1234, 32'h0000_0055};
    vecs[9] = '{3'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988};

    // Reset state, with an MFHI presented so stall/MDUE are exercised.
    start = 1'b1;
    op = 3'd6;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_hi", {32'd0, HI}, 64'd0);
    chk("reset_lo", {32'd0, LO}, 64'd0);
    chk("reset_mdue", {32'd0, MDUE}, 64'd0);
    start = 1'b0;
    #2 reset = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, c);
      chk($sformatf("vec%0d_cycles", i), 64'(c), 64'(exp_lat(vecs[i].op)));
      chk($sformatf("vec%0d_hi", i), {32'd0, HI}, {32'd0, vecs[i].hi});
      chk($sformatf("vec%0d_lo", i), {32'd0, LO}, {32'd0, vecs[i].lo});
    end

    // DIVU followed by MFLO held at start: stalls for the whole divide.
    start = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd7;
    step();
    op = 3'd7;
    n = 0;
    while (stall && n < 100) begin n++; step(); end
    chk("mflo_stall_cycles", 64'(n), 64'd10);
    chk("mflo_mdue", {32'd0, MDUE}, 64'd14);
    chk("mflo_hi", {32'd0, HI}, 64'd2);
    $display("[TB] DIVU 100/7 then MFLO: stall_cycles=%0d MDUE=%h", n, MDUE);
    start = 1'b0;

    // MULT arriving on the completion edge waits one cycle, then runs.
    start = 1'b1; op = 3'd3; rs = 32'd9; rt = 32'd2;
    step();
    op = 3'd0; rs = 32'd3; rt = 32'd5;
    n = 0;
    while (stall && n < 100) begin n++; step(); end
    chk("b2b_stall_cycles", 64'(n), 64'd10);
    step();
    start = 1'b0;
    c = 0;
    while (busy && c < 100) begin c++; step(); end
    chk("b2b_mult_cycles", 64'(c), 64'd5);
    chk("b2b_mult_hilo", {HI, LO}, 64'd15);
    $display("[TB] DIVU then back-to-back MULT 3*5: HI=%h LO=%h", HI, LO);

    // Flush coinciding with start blocks both accept and MTLO.
    start = 1'b1; GeneralFlush = 1'b1; op = 3'd0; rs = 32'd7; rt = 32'd7;
    step();
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    op = 3'd5; rs = 32'd99;
    step();
    start = 1'b0; GeneralFlush = 1'b0;
    chk("flush_mtlo_lo", {32'd0, LO}, 64'd15);
    $display("[TB] start under flush: busy=%0d LO=%h", busy, LO);

    // Flush in the first BUSY cycle cancels the MULT.
    run_op(3'd5, 32'd9, 32'd0, c);
    run_op(3'd4, 32'd7, 32'd0, c);
    start = 1'b1; op = 3'd0; rs = 32'd2; rt = 32'd3;
    step();
    start = 1'b0;
    c = 0;
    while (busy && c < 100) begin c++; GeneralFlush = (c == 1); step(); end
    GeneralFlush = 1'b0;
    chk("cancel_cycles", 64'(c), 64'd1);
    repeat (8) step();
    chk("cancel_hilo", {HI, LO}, {32'd7, 32'd9});
    $display("[TB] MULT 2*3 cancelled: HI=%h LO=%h", HI, LO);

    // Flush at BUSY cycle 3 is ignored.
    start = 1'b1; op = 3'd0; rs = 32'd4; rt = 32'd4;
    step();
    start = 1'b0;
    c = 0;
    while (busy && c < 100) begin c++; GeneralFlush = (c == 3); step(); end
    GeneralFlush = 1'b0;
    chk("late_flush_cycles", 64'(c), 64'd5);
    chk("late_flush_hilo", {HI, LO}, 64'd16);
    $display("[TB] MULT 4*4 with late flush: HI=%h LO=%h", HI, LO);

    // Reset during a DIV clears everything immediately and nothing lands later.
    run_op(3'd4, 32'hABC, 32'd0, c);
    start = 1'b1; op = 3'd2; rs = 32'd100; rt = 32'd3;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_hilo", {HI, LO}, 64'd0);
    #2 reset = 1'b1;
    repeat (15) step();
    chk("postreset_busy", {63'd0, busy}, 64'd0);
    chk("postreset_hilo", {HI, LO}, 64'd0);
    $display("[TB] reset during DIV: busy=%0d HI=%h LO=%h", busy, HI, LO);
    m_hi = 32'd0;
    m_lo = 32'd0;

    op = 3'd0;
    #1;
    chk("mdue_other_op", {32'd0, MDUE}, 64'd0);

    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      e = ref_calc(o, a, b, m_hi, m_lo);
      run_op(o, a, b, c);
      chk($sformatf("rnd%0d_cycles", k), 64'(c), 64'(exp_lat(o)));
      chk($sformatf("rnd%0d_hilo", k), {HI, LO}, e);
      m_hi = e[63:32];
      m_lo = e[31:0];
      op = 3'd6;
      #1;
      chk($sformatf("rnd%0d_mfhi", k), {32'd0, MDUE}, {32'd0, m_hi});
      op = 3'd7;
      #1;
      chk($sformatf("rnd%0d_mflo", k), {32'd0, MDUE}, {32'd0, m_lo});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL implement the already-decided clocking: one clock; reset is asynchronous and active-low.
REQ-002 SHALL expose parameters: MULT_LAT, default 5, busy cycles for MULT/MULTU; DIV_LAT, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL expose ports:
- clock  in  1  rising-edge clock
- reset  in  1  async active-low reset
- start  in  1  E-stage instruction is an MDU op this cycle
- op  in  `MDOp_len  MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
- rs  in  32  forwarded rs operand
- rt  in  32  forwarded rt operand
- GeneralFlush  in  1  pipeline-wide flush, same signal that clears E_M
- busy  out  1  multi-cycle op in progress
- stall  out  1  hold F/D/E and bubble E_M
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- MDUE  out  32  MFHI/MFLO read data for E_M

Function
REQ-004 SHALL have states IDLE and BUSY, with a down-counter cnt sized for max(MULT_LAT, DIV_LAT).
REQ-005 SHALL accept a MULT/MULTU/DIV/DIVU in IDLE when start=1, stall=0 and GeneralFlush=0; it then latches rs, rt and op, loads cnt=LAT, and enters BUSY on the next edge.
REQ-006 SHALL decrement cnt each BUSY cycle; when cnt reaches 1, it writes HI/LO and returns to IDLE on that edge, giving LAT busy cycles in total.
REQ-007 SHALL drive busy=1 exactly while in BUSY.
REQ-008 SHALL assert stall combinationally when start=1 and any op is presented while (busy=1 or a mult/div is being accepted this cycle is excluded); stall=0 for all cases other than start with busy=1.
REQ-009 SHALL compute results as follows:
- MULT: {HI,LO} = signed 64-bit product.
- MULTU: {HI,LO} = unsigned 64-bit product.
- DIV: LO = signed quotient, HI = signed remainder, truncating toward zero.
- DIVU: the unsigned equivalent of DIV.
REQ-010 SHALL handle division corner cases: rt=0 gives LO=32'hFFFF_FFFF and HI=rs; DIV of 32'h8000_0000 by 32'hFFFF_FFFF gives LO=32'h8000_0000 and HI=0.
REQ-011 SHALL write MTHI/MTLO from rs into HI/LO on the same edge when start=1, stall=0 and GeneralFlush=0; it does not enter BUSY.
REQ-012 SHALL drive MDUE combinationally: HI for MFHI, LO for MFLO, 0 otherwise; it is valid only when stall=0.
REQ-013 SHALL give GeneralFlush with start=1 priority: no accept, no HI/LO write.
REQ-014 SHALL treat GeneralFlush in the first BUSY cycle (cnt=LAT, i.e. the op has advanced to M and is the flushed instruction) as a cancel: return to IDLE, no HI/LO write.
REQ-015 SHALL ignore GeneralFlush in later BUSY cycles; the op completes.
REQ-016 SHALL let the completion edge and a new start coincide: the new op sees stall=1 on that cycle (busy still 1) and is accepted on the following cycle using the updated HI/LO.

Reset
REQ-017 SHALL, on reset low, immediately force: state=IDLE, cnt=0, HI=0, LO=0, latched operands=0, busy=0.
REQ-018 SHALL, with reset low, drive stall=0, and MDUE reflects HI/LO=0.
REQ-019 SHALL abort any in-flight op on reset mid-operation, with no HI/LO update after reset release.

Structure
REQ-020 SHALL place the op encodings, `MDOp_len, and the default MULT_LAT/DIV_LAT constants in def.v.
REQ-021 SHALL use one sub-module, mdu_arith: a combinational 64-bit product and quotient/remainder with the corner cases of REQ-010.
REQ-022 SHALL keep the FSM, counter and HI/LO registers in mdu_ctrl.

Verification
REQ-023 SHALL cover: MULT rs=32'hFFFF_FFFE, rt=3 -> busy for 5 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
REQ-024 SHALL cover: DIVU rs=100, rt=7, then MFLO at the next start -> stall high for 10 cycles, then MDUE=14, with HI=2.
REQ-025 SHALL cover: DIV rs=5, rt=0 -> after 10 cycles LO=32'hFFFF_FFFF, HI=5.
REQ-026 SHALL cover: MULT 2*3 accepted, then GeneralFlush on the first BUSY cycle -> busy drops on the next edge; HI/LO keep their prior values (e.g. MTLO 9 earlier gives LO=9).
REQ-027 SHALL cover: MULT 4*4 with GeneralFlush at cycle 3 of BUSY -> completes, LO=16.
REQ-028 SHALL cover: reset low at cycle 2 of a DIV -> busy=0 and HI=LO=0 immediately; after release, no late write occurs.
